tacho_capture: RTL and testbench

TACHO_CAPTURE -- requirements
Module: tacho_capture

---
 rtl/tacho_pkg.sv | 29 ++
 rtl/tacho_sync_filter.sv | 69 ++++++
 rtl/tacho_capture.sv | 188 ++++++++++++++++++
 tb/tb_tacho_capture.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tacho_pkg.sv
// Shared types and sizing for the tachometer capture block.
// FSM encoding, counter widths and glitch-filter depth live here.
package tacho_pkg;

    localparam int CNT_W      = 32;
    localparam int PHA_W      = 31;
    localparam int FILT_DEPTH = 4;
    localparam int FILT_CW    = $clog2(FILT_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FIRST = 2'd1,
        ST_MEASURE    = 2'd2,
        ST_STALL      = 2'd3
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [PHA_W-1:0] sat_inc_pha(
        input logic [PHA_W-1:0] v
    );
        return (&v) ? v : v + PHA_W'(1);
    endfunction

endpackage

// File: rtl/tacho_sync_filter.sv
// Two-flop synchronizer, optional glitch filter and rising-edge detect.
// Filter is enabled by defining TACHO_GLITCH_FILTER_EN.
module tacho_sync_filter
    import tacho_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic s1_q;
    logic s1_d;
    logic s2_q;
    logic s2_d;
    logic hist_q;
    logic hist_d;

`ifdef TACHO_GLITCH_FILTER_EN
    logic               filt_q;
    logic               filt_d;
    logic [FILT_CW-1:0] run_q;
    logic [FILT_CW-1:0] run_d;
`endif

    always_comb begin
        s1_d = din;
        s2_d = s1_q;
`ifdef TACHO_GLITCH_FILTER_EN
        filt_d = filt_q;
        run_d  = '0;
        // level only follows after FILT_DEPTH consecutive differing samples
        if (s2_q != filt_q) begin
            if (run_q == FILT_CW'(FILT_DEPTH - 1)) begin
                filt_d = s2_q;
            end else begin
                run_d = run_q + FILT_CW'(1);
            end
        end
        level = filt_q;
`else
        level = s2_q;
`endif
        hist_d = level;
        rise   = level & ~hist_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            hist_q <= 1'b0;
`ifdef TACHO_GLITCH_FILTER_EN
            filt_q <= 1'b0;
            run_q  <= '0;
`endif
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            hist_q <= hist_d;
`ifdef TACHO_GLITCH_FILTER_EN
            filt_q <= filt_d;
            run_q  <= run_d;
`endif
        end
    end

endmodule

// File: rtl/tacho_capture.sv
// Tachometer period/phase capture with stall detection.
// Optional input glitch filter: define TACHO_GLITCH_FILTER_EN.
module tacho_capture
    import tacho_pkg::*;
(
    input  logic        I_clk,
    input  logic        I_reset_n,
    input  logic        I_spd1,
    input  logic        I_spd2,
    input  logic        I_stat,
    input  logic        I_clear,
    input  logic [31:0] I_timeout,
    output logic [31:0] O_period,
    output logic [31:0] O_pha,
    output logic [31:0] O_report_pulse,
    output logic        O_valid,
    output logic        O_stall
);

    logic spd1_rise;
    logic spd1_level_unused;
    logic spd2_rise;
    logic spd2_lvl;
    logic clr_rise;
    logic clr_level_unused;

    state_e state_q;
    state_e state_d;

    logic [CNT_W-1:0] per_cnt_q;
    logic [CNT_W-1:0] per_cnt_d;
    logic [PHA_W-1:0] pha_cnt_q;
    logic [PHA_W-1:0] pha_cnt_d;
    logic             pha_arm_q;
    logic             pha_arm_d;
    logic             dir_q;
    logic             dir_d;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] period_d;
    logic [CNT_W-1:0] pha_q;
    logic [CNT_W-1:0] pha_d;
    logic [CNT_W-1:0] rpt_q;
    logic [CNT_W-1:0] rpt_d;
    logic             valid_q;
    logic             valid_d;

    logic stall_hit;
    logic counting;

    tacho_sync_filter u_spd1 (
        .clk   (I_clk),
        .rst_n (I_reset_n),
        .din   (I_spd1),
        .level (spd1_level_unused),
        .rise  (spd1_rise)
    );

    tacho_sync_filter u_spd2 (
        .clk   (I_clk),
        .rst_n (I_reset_n),
        .din   (I_spd2),
        .level (spd2_lvl),
        .rise  (spd2_rise)
    );

    tacho_sync_filter u_clr (
        .clk   (I_clk),
        .rst_n (I_reset_n),
        .din   (I_clear),
        .level (clr_level_unused),
        .rise  (clr_rise)
    );

    assign stall_hit = (I_timeout != '0) && (per_cnt_q == I_timeout);
    assign counting  = (state_q == ST_WAIT_FIRST) || (state_q == ST_MEASURE);

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!I_stat) begin
            state_d = ST_IDLE;
        end else if (clr_rise) begin
            state_d = ST_WAIT_FIRST;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT_FIRST;
                end
                ST_WAIT_FIRST, ST_MEASURE: begin
                    if (spd1_rise) begin
                        state_d = ST_MEASURE;
                    end else if (stall_hit) begin
                        state_d = ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (spd1_rise) begin
                        state_d = ST_MEASURE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        O_stall        = (state_q == ST_STALL);
        O_valid        = valid_q;
        O_period       = period_q;
        O_pha          = pha_q;
        O_report_pulse = rpt_q;
    end

    always_comb begin
        per_cnt_d = sat_inc_cnt(per_cnt_q);
        pha_cnt_d = sat_inc_pha(pha_cnt_q);
        pha_arm_d = pha_arm_q;
        dir_d     = dir_q;
        period_d  = period_q;
        pha_d     = pha_q;
        rpt_d     = rpt_q;
        valid_d   = valid_q;

        // disable, idle and clear all discard every partial measurement
        if (!I_stat || (state_q == ST_IDLE) || clr_rise) begin
            per_cnt_d = '0;
            pha_cnt_d = '0;
            pha_arm_d = 1'b0;
            dir_d     = 1'b0;
            period_d  = '0;
            pha_d     = '0;
            rpt_d     = '0;
            valid_d   = 1'b0;
        end else if (spd1_rise) begin
            rpt_d     = rpt_q + 32'd1;
            per_cnt_d = CNT_W'(1);
            pha_cnt_d = '0;
            pha_arm_d = !spd2_rise;
            dir_d     = spd2_lvl && !spd2_rise;
            if (state_q == ST_MEASURE) begin
                period_d = per_cnt_q;
                valid_d  = 1'b1;
                if (spd2_rise) begin
                    pha_d = '0;
                end
            end
        end else begin
            if (stall_hit && counting) begin
                period_d = '0;
                valid_d  = 1'b0;
            end
            // phase count includes the clock on which spd2 rises
            if (spd2_rise && pha_arm_q && (state_q == ST_MEASURE)) begin
                pha_d     = {dir_q, sat_inc_pha(pha_cnt_q)};
                pha_arm_d = 1'b0;
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            per_cnt_q <= '0;
            pha_cnt_q <= '0;
            pha_arm_q <= 1'b0;
            dir_q     <= 1'b0;
            period_q  <= '0;
            pha_q     <= '0;
            rpt_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            per_cnt_q <= per_cnt_d;
            pha_cnt_q <= pha_cnt_d;
            pha_arm_q <= pha_arm_d;
            dir_q     <= dir_d;
            period_q  <= period_d;
            pha_q     <= pha_d;
            rpt_q     <= rpt_d;
            valid_q   <= valid_d;
        end
    end

endmodule

// File: tb/tb_tacho_capture.sv
// Self-checking bench for tacho_capture: waveform generator plus
// arithmetic reference for period, phase, direction and edge counts.
module tb_tacho_capture;

    logic        I_clk = 1'b0;
    logic        I_reset_n;
    logic        I_spd1;
    logic        I_spd2;
    logic        I_stat;
    logic        I_clear;
    logic [31:0] I_timeout;
    logic [31:0] O_period;
    logic [31:0] O_pha;
    logic [31:0] O_report_pulse;
    logic        O_valid;
    logic        O_stall;

`ifdef TACHO_GLITCH_FILTER_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif

    int   n_chk = 0;
    int   n_pass = 0;
    int   exp_rises = 0;
    int   clear_at = -1;
    logic s1_prev = 1'b0;

    tacho_capture dut (
        .I_clk          (I_clk),
        .I_reset_n      (I_reset_n),
        .I_spd1         (I_spd1),
        .I_spd2         (I_spd2),
        .I_stat         (I_stat),
        .I_clear        (I_clear),
        .I_timeout      (I_timeout),
        .O_period       (O_period),
        .O_pha          (O_pha),
        .O_report_pulse (O_report_pulse),
        .O_valid        (O_valid),
        .O_stall        (O_stall)
    );

    always #20 I_clk = ~I_clk;

    initial begin
        #4000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // spd1 high for the first half of each period; spd2 is spd1 delayed by d
    task automatic gen(input int p, input int d, input int t0, input int t1);
        int h;
        h = p / 2;
        for (int t = t0; t < t1; t++) begin
            @(negedge I_clk);
            I_spd1 = ((t % p) < h);
            I_spd2 = ((((t - d) % p) + p) % p) < h;
            if (t == clear_at) I_clear = 1'b1;
            if (I_spd1 && !s1_prev) exp_rises++;
            s1_prev = I_spd1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge I_clk);
    endtask

    task automatic restart();
        @(negedge I_clk);
        I_stat    = 1'b0;
        I_spd1    = 1'b0;
        I_spd2    = 1'b0;
        I_clear   = 1'b0;
        I_timeout = 32'd0;
        clear_at  = -1;
        s1_prev   = 1'b0;
        exp_rises = 0;
        idle(6);
        I_stat = 1'b1;
        idle(2);
    endtask

    task automatic test_reset();
        logic [97:0] obs;
        I_reset_n = 1'b0;
        I_stat    = 1'b0;
        I_spd1    = 1'b0;
        I_spd2    = 1'b0;
        I_clear   = 1'b0;
        I_timeout = 32'd0;
        idle(3);
        obs = {O_period, O_pha, O_report_pulse, O_valid, O_stall};
        n_chk++;
        if (obs !== '0) $display("FAIL reset_outputs got %h want 0", obs);
        else n_pass++;
        I_reset_n = 1'b1;
        I_stat    = 1'b1;
        idle(4);
        obs = {O_period, O_pha, O_report_pulse, O_valid, O_stall};
        n_chk++;
        if (obs !== '0) $display("FAIL wait_first_quiet got %h want 0", obs);
        else n_pass++;
    endtask

    task automatic test_fixed_lead();
        restart();
        gen(1000, 250, 0, LAT);
        n_chk++;
        if (O_report_pulse !== 32'd0)
            $display("FAIL edge_too_early got %0d want 0", O_report_pulse);
        else n_pass++;
        gen(1000, 250, LAT, LAT + 1);
        n_chk++;
        if (O_report_pulse !== 32'd1)
            $display("FAIL edge_latency got %0d want 1", O_report_pulse);
        else n_pass++;
        gen(1000, 250, LAT + 1, 1000 + LAT);
        n_chk++;
        if (O_valid !== 1'b0)
            $display("FAIL valid_before_second got %b want 0", O_valid);
        else n_pass++;
        gen(1000, 250, 1000 + LAT, 1000 + LAT + 1);
        n_chk++;
        if (O_valid !== 1'b1 || O_period !== 32'd1000)
            $display("FAIL fixed_period got v=%b p=%0d want v=1 p=1000",
                     O_valid, O_period);
        else n_pass++;
        gen(1000, 250, 1000 + LAT + 1, 1300);
        n_chk++;
        if (O_pha !== 32'h0000_00FA)
            $display("FAIL fixed_pha got %h want 000000fa", O_pha);
        else n_pass++;
    endtask

    task automatic test_spd2_leads();
        restart();
        gen(1000, 750, 0, 5000);
        idle(LAT + 2);
        n_chk++;
        if (O_pha !== {1'b1, 31'd750} || O_period !== 32'd1000)
            $display("FAIL lead_pha got pha=%h p=%0d want pha=800002ee p=1000",
                     O_pha, O_period);
        else n_pass++;
    endtask

    task automatic test_random();
        int p;
        int d;
        int h;
        logic dir;
        logic [31:0] exp_pha;
        for (int it = 0; it < 5; it++) begin
            restart();
            p = int'($urandom_range(40, 300));
            d = int'($urandom_range(1, p - 1));
            h = p / 2;
            gen(p, d, 0, 5 * p);
            idle(LAT + 2);
            dir = (((4 * p - d) % p) < h);
            exp_pha = {dir, 31'(d)};
            n_chk++;
            if (O_period !== 32'(p) || O_valid !== 1'b1)
                $display("FAIL rnd_period got p=%0d v=%b want p=%0d v=1",
                         O_period, O_valid, p);
            else n_pass++;
            n_chk++;
            if (O_pha !== exp_pha)
                $display("FAIL rnd_pha got %h want %h (p=%0d d=%0d)",
                         O_pha, exp_pha, p, d);
            else n_pass++;
            n_chk++;
            if (O_report_pulse !== 32'(exp_rises))
                $display("FAIL rnd_count got %0d want %0d",
                         O_report_pulse, exp_rises);
            else n_pass++;
            n_chk++;
            if (O_stall !== 1'b0)
                $display("FAIL rnd_stall got %b want 0", O_stall);
            else n_pass++;
        end
    endtask

    task automatic test_simultaneous();
        restart();
        gen(60, 0, 0, 200);
        idle(LAT + 2);
        n_chk++;
        if (O_pha !== 32'd0 || O_period !== 32'd60 || O_valid !== 1'b1)
            $display("FAIL simul got pha=%h p=%0d v=%b want 0 60 1",
                     O_pha, O_period, O_valid);
        else n_pass++;
    endtask

    task automatic test_stall();
        int k;
        restart();
        I_timeout = 32'd5000;
        gen(1000, 250, 0, 2001);
        k = 0;
        while (k < 20 && O_report_pulse !== 32'(exp_rises)) begin
            @(negedge I_clk);
            k++;
        end
        n_chk++;
        if (k !== LAT) $display("FAIL stall_edge_lat got %0d want %0d", k, LAT);
        else n_pass++;
        while (k < 6000 + LAT && O_stall !== 1'b1) begin
            @(negedge I_clk);
            k++;
        end
        n_chk++;
        if (k - LAT !== 5000)
            $display("FAIL stall_time got %0d want 5000", k - LAT);
        else n_pass++;
        n_chk++;
        if (O_stall !== 1'b1 || O_period !== 32'd0 || O_valid !== 1'b0)
            $display("FAIL stall_out got s=%b p=%0d v=%b want 1 0 0",
                     O_stall, O_period, O_valid);
        else n_pass++;
        @(negedge I_clk);
        I_spd1  = 1'b0;
        s1_prev = 1'b0;
        idle(10);
        gen(1000, 250, 0, LAT + 2);
        n_chk++;
        if (O_stall !== 1'b0 || O_valid !== 1'b0)
            $display("FAIL stall_exit got s=%b v=%b want 0 0", O_stall, O_valid);
        else n_pass++;
        gen(1000, 250, LAT + 2, 1000 + LAT + 1);
        n_chk++;
        if (O_valid !== 1'b1 || O_period !== 32'd1000)
            $display("FAIL stall_recover got v=%b p=%0d want 1 1000",
                     O_valid, O_period);
        else n_pass++;
        I_timeout = 32'd0;
    endtask

    task automatic test_clear();
        restart();
        clear_at = 2000;
        gen(20, 5, 0, 2000);
        n_chk++;
        if (O_report_pulse !== 32'd100)
            $display("FAIL clr_pre_count got %0d want 100", O_report_pulse);
        else n_pass++;
        gen(20, 5, 2000, 2000 + LAT + 2);
        n_chk++;
        if (O_report_pulse !== 32'd0 || O_valid !== 1'b0 ||
            O_period !== 32'd0 || O_pha !== 32'd0 || O_stall !== 1'b0)
            $display("FAIL clr_outputs got r=%0d v=%b p=%0d pha=%h s=%b want 0",
                     O_report_pulse, O_valid, O_period, O_pha, O_stall);
        else n_pass++;
        I_clear  = 1'b0;
        clear_at = -1;
        gen(20, 5, 2000 + LAT + 2, 2020 + LAT + 1);
        n_chk++;
        if (O_report_pulse !== 32'd1 || O_valid !== 1'b0)
            $display("FAIL clr_wait_first got r=%0d v=%b want 1 0",
                     O_report_pulse, O_valid);
        else n_pass++;
        gen(20, 5, 2020 + LAT + 1, 2040 + LAT + 1);
        n_chk++;
        if (O_valid !== 1'b1 || O_period !== 32'd20)
            $display("FAIL clr_resume got v=%b p=%0d want 1 20",
                     O_valid, O_period);
        else n_pass++;
    endtask

    task automatic test_stat_reset();
        logic [97:0] obs;
        restart();
        gen(200, 50, 0, 350);
        n_chk++;
        if (O_valid !== 1'b1 || O_period !== 32'd200 || O_pha !== 32'd50)
            $display("FAIL stat_pre got v=%b p=%0d pha=%h want 1 200 32",
                     O_valid, O_period, O_pha);
        else n_pass++;
        I_stat = 1'b0;
        idle(1);
        obs = {O_period, O_pha, O_report_pulse, O_valid, O_stall};
        n_chk++;
        if (obs !== '0) $display("FAIL stat_drop got %h want 0", obs);
        else n_pass++;
        I_stat = 1'b1;
        gen(200, 50, 351, 520);
        n_chk++;
        if (O_report_pulse !== 32'd1 || O_valid !== 1'b0)
            $display("FAIL stat_rearm got r=%0d v=%b want 1 0",
                     O_report_pulse, O_valid);
        else n_pass++;
        #5;
        I_reset_n = 1'b0;
        #1;
        obs = {O_period, O_pha, O_report_pulse, O_valid, O_stall};
        n_chk++;
        if (obs !== '0) $display("FAIL async_reset got %h want 0", obs);
        else n_pass++;
        idle(3);
        I_reset_n = 1'b1;
        gen(200, 50, 520, 600 + LAT + 1);
        n_chk++;
        if (O_report_pulse !== 32'd1 || O_valid !== 1'b0 || O_period !== 32'd0)
            $display("FAIL reset_release got r=%0d v=%b p=%0d want 1 0 0",
                     O_report_pulse, O_valid, O_period);
        else n_pass++;
    endtask

    task automatic test_glitch();
        restart();
        gen(100, 30, 0, 260);
        @(negedge I_clk);
        I_spd1 = 1'b1;
        idle(2);
        I_spd1 = 1'b0;
        idle(15);
        n_chk++;
`ifdef TACHO_GLITCH_FILTER_EN
        if (O_report_pulse !== 32'd3)
            $display("FAIL glitch_count got %0d want 3", O_report_pulse);
        else n_pass++;
`else
        if (O_report_pulse !== 32'd4)
            $display("FAIL short_pulse_count got %0d want 4", O_report_pulse);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_fixed_lead();
        test_spd2_leads();
        test_random();
        test_simultaneous();
        test_stall();
        test_clear();
        test_stat_reset();
        test_glitch();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
